// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 31-instruction MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB
// from a one-hot instruction code, handshakes with both memories, traps and counts retirements.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      code,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic [1:0]       rf_dsel,
  output logic             alu_bsrc,
  output logic             ext_sign,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;
  localparam int         TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  // Instruction class flags; the registered copy stands in for the captured code.
  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic jal;
    logic imm;
    logic sext;
  } cls_t;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  cls_t             r_cls;
  cls_t             w_cls;
  logic [TW-1:0]    r_wait;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;
  logic             w_wait;
  logic             w_limit;
  logic             w_onehot;
  logic             w_taken;

  // Bit 31 has no instruction assigned, so a lone bit 31 is as illegal as zero or multi-hot.
  assign w_onehot = (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0) && !code[31];

  always_comb begin
    w_cls       = '0;
    w_cls.alu_r = |code[15:0];
    w_cls.alu_i = (|code[22:17]) | code[27] | code[28];
    w_cls.lw    = code[23];
    w_cls.sw    = code[24];
    w_cls.beq   = code[25];
    w_cls.bne   = code[26];
    w_cls.jal   = code[30];
    w_cls.imm   = |code[28:17];
    w_cls.sext  = code[17] | code[18] | (|code[28:23]);
  end

  assign w_taken = (r_cls.beq & alu_zero) | (r_cls.bne & ~alu_zero);
  assign w_limit = (MEM_TIMEOUT != 0) && (r_wait == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cls   <= '0;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
      if (w_wait && (w_next == r_state) && (MEM_TIMEOUT != 0)) r_wait <= r_wait + TW'(1);
      else                                                       r_wait <= '0;
      if (w_retire && (r_count != {CNT_W{1'b1}})) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_wait   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_ready) w_next = S_DECODE;
        else begin
          w_wait = 1'b1;
          if (w_limit) w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_next = S_TRAP;
        if (w_onehot) begin
          if (code[29] | code[16]) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end else if (code[30]) w_next = S_WB;
          else                   w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cls.beq | r_cls.bne) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (r_cls.lw | r_cls.sw)       w_next = S_MEM;
        else if (r_cls.alu_r | r_cls.alu_i)     w_next = S_WB;
        else                                    w_next = S_TRAP;
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (r_cls.sw) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end else w_next = S_WB;
        end else begin
          w_wait = 1'b1;
          if (w_limit) w_next = S_TRAP;
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_TRAP;
    endcase
  end

  // Everything is forced low while rst is high so an aborted instruction writes nothing.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    rf_we    = 1'b0;
    rf_wsel  = 2'd0;
    rf_dsel  = 2'd0;
    alu_bsrc = 1'b0;
    ext_sign = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    trap     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_DECODE: begin
          if (w_onehot) begin
            if (code[29] | code[30]) begin
              pc_we  = 1'b1;
              pc_src = 2'd2;
            end else if (code[16]) begin
              pc_we  = 1'b1;
              pc_src = 2'd3;
            end
          end
        end
        S_EXEC: begin
          alu_bsrc = r_cls.imm;
          ext_sign = r_cls.sext;
          if (w_taken) begin
            pc_we  = 1'b1;
            pc_src = 2'd1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = r_cls.sw;
        end
        S_WB: begin
          rf_we = 1'b1;
          if (r_cls.jal) begin
            rf_wsel = 2'd2;
            rf_dsel = 2'd2;
          end else if (r_cls.lw) begin
            rf_wsel = 2'd1;
            rf_dsel = 2'd1;
          end else if (r_cls.alu_i) rf_wsel = 2'd1;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle,
// plus illegal codes, fetch timeout and reset abort, with a narrow-counter copy for saturation.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] code;
  logic        alu_zero, imem_ready, dmem_ready;

  logic        imem_req, ir_we, pc_we, rf_we, alu_bsrc, ext_sign, dmem_req, dmem_we, trap;
  logic [1:0]  pc_src, rf_wsel, rf_dsel;
  logic [2:0]  state;
  logic [31:0] instr_count;

  logic        imem_req_b, ir_we_b, pc_we_b, rf_we_b, alu_bsrc_b, ext_sign_b, dmem_req_b, dmem_we_b, trap_b;
  logic [1:0]  pc_src_b, rf_wsel_b, rf_dsel_b;
  logic [2:0]  state_b;
  logic [1:0]  instr_count_b;

  logic [5:0]  strb;
  logic [7:0]  sel;
  int          checks = 0;
  int          failures = 0;

  assign strb = {imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we};
  assign sel  = {pc_src, rf_wsel, rf_dsel, alu_bsrc, ext_sign};

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .code(code), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_dsel(rf_dsel),
    .alu_bsrc(alu_bsrc), .ext_sign(ext_sign), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .state(state), .trap(trap), .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNT_W(2), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .code(code), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req_b), .ir_we(ir_we_b), .pc_we(pc_we_b), .pc_src(pc_src_b),
    .rf_we(rf_we_b), .rf_wsel(rf_wsel_b), .rf_dsel(rf_dsel_b),
    .alu_bsrc(alu_bsrc_b), .ext_sign(ext_sign_b), .dmem_req(dmem_req_b), .dmem_we(dmem_we_b),
    .state(state_b), .trap(trap_b), .instr_count(instr_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lets combinational outputs settle after the latest input change, then checks one cycle.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [5:0] s, input logic [7:0] m);
    #1;
    chk({tag, "_state"}, {29'd0, state}, {29'd0, st});
    chk({tag, "_strb"}, {26'd0, strb}, {26'd0, s});
    chk({tag, "_sel"}, {24'd0, sel}, {24'd0, m});
  endtask

  initial begin
    rst = 1'b1; code = 32'd0; alu_zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    tick();
    expect_cyc("rst", 3'd0, 6'b000000, 8'h00);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_count", instr_count, 32'd0);

    // add with instant ready: FETCH, DECODE, EXEC, WB
    rst = 1'b0; code = 32'h1;
    expect_cyc("add_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("add_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("add_e", 3'd2, 6'b000000, 8'h00); tick();
    alu_zero = 1'b1;
    expect_cyc("add_w", 3'd4, 6'b000100, 8'h00); tick();
    alu_zero = 1'b0;
    chk("add_count", instr_count, 32'd1);
    chk("add_count_b", {30'd0, instr_count_b}, 32'd1);

    // lw with dmem_ready arriving on the fourth MEM cycle
    code = 32'h1 << 23; dmem_ready = 1'b0;
    expect_cyc("lw_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("lw_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("lw_e", 3'd2, 6'b000000, 8'b00000011); tick();
    for (int i = 0; i < 3; i++) begin
      expect_cyc("lw_mwait", 3'd3, 6'b000010, 8'h00); tick();
    end
    dmem_ready = 1'b1;
    expect_cyc("lw_mdone", 3'd3, 6'b000010, 8'h00); tick();
    dmem_ready = 1'b0;
    expect_cyc("lw_w", 3'd4, 6'b000100, 8'b00010100); tick();
    chk("lw_count", instr_count, 32'd2);

    // beq/bne taken and not taken
    code = 32'h1 << 25; alu_zero = 1'b1;
    expect_cyc("beq1_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("beq1_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("beq1_e", 3'd2, 6'b001000, 8'b01000011); tick();
    alu_zero = 1'b0;
    expect_cyc("beq0_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("beq0_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("beq0_e", 3'd2, 6'b000000, 8'b00000011); tick();
    code = 32'h1 << 26;
    expect_cyc("bne0_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("bne0_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("bne0_e", 3'd2, 6'b001000, 8'b01000011); tick();
    alu_zero = 1'b1;
    expect_cyc("bne1_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("bne1_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("bne1_e", 3'd2, 6'b000000, 8'b00000011); tick();
    alu_zero = 1'b0;
    chk("br_count", instr_count, 32'd6);
    chk("sat_count_b", {30'd0, instr_count_b}, 32'd3);

    // jal: the WB cycle must use the captured code, not the live input
    code = 32'h1 << 30;
    expect_cyc("jal_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("jal_d", 3'd1, 6'b001000, 8'b10000000); tick();
    code = 32'h1;
    expect_cyc("jal_w", 3'd4, 6'b000100, 8'b00101000); tick();
    chk("jal_count", instr_count, 32'd7);

    // jr and j retire straight from DECODE
    code = 32'h1 << 16;
    expect_cyc("jr_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("jr_d", 3'd1, 6'b001000, 8'b11000000); tick();
    code = 32'h1 << 29;
    expect_cyc("j_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("j_d", 3'd1, 6'b001000, 8'b10000000); tick();
    chk("jump_count", instr_count, 32'd9);

    // sw with instant ready
    code = 32'h1 << 24; dmem_ready = 1'b1;
    expect_cyc("sw_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("sw_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("sw_e", 3'd2, 6'b000000, 8'b00000011); tick();
    expect_cyc("sw_m", 3'd3, 6'b000011, 8'h00); tick();
    chk("sw_count", instr_count, 32'd10);

    // code=0 traps; trap is sticky and silent until reset
    code = 32'd0;
    expect_cyc("z_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("z_d", 3'd1, 6'b000000, 8'h00); tick();
    for (int i = 0; i < 3; i++) begin
      expect_cyc("z_trap", 3'd7, 6'b000000, 8'h00);
      chk("z_trap_flag", {31'd0, trap}, 32'd1);
      tick();
    end
    chk("z_trap_count", instr_count, 32'd10);
    rst = 1'b1;
    expect_cyc("z_rst", 3'd7, 6'b000000, 8'h00);
    chk("z_rst_trap", {31'd0, trap}, 32'd0);
    tick();
    expect_cyc("z_rst_after", 3'd0, 6'b000000, 8'h00);
    chk("z_rst_count", instr_count, 32'd0);

    // multi-hot code traps
    rst = 1'b0; code = 32'h3;
    expect_cyc("mh_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("mh_d", 3'd1, 6'b000000, 8'h00); tick();
    expect_cyc("mh_trap", 3'd7, 6'b000000, 8'h00);
    chk("mh_trap_flag", {31'd0, trap}, 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0;

    // fetch timeout: four unanswered request cycles lead to TRAP
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_cyc("to_wait", 3'd0, 6'b100000, 8'h00); tick();
    end
    expect_cyc("to_trap", 3'd7, 6'b000000, 8'h00);
    chk("to_trap_flag", {31'd0, trap}, 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0;

    // ready on the fourth cycle completes the fetch instead of trapping
    for (int i = 0; i < 3; i++) begin
      expect_cyc("rdy4_wait", 3'd0, 6'b100000, 8'h00); tick();
    end
    imem_ready = 1'b1; code = 32'h1 << 24; dmem_ready = 1'b0;
    expect_cyc("rdy4_f", 3'd0, 6'b111000, 8'h00); tick();
    expect_cyc("rdy4_d", 3'd1, 6'b000000, 8'h00); tick();
    chk("rdy4_trap_flag", {31'd0, trap}, 32'd0);

    // reset during the sw MEM cycle aborts the store
    expect_cyc("ab_e", 3'd2, 6'b000000, 8'b00000011); tick();
    expect_cyc("ab_m", 3'd3, 6'b000011, 8'h00);
    rst = 1'b1;
    expect_cyc("ab_rst", 3'd3, 6'b000000, 8'h00);
    tick();
    expect_cyc("ab_after", 3'd0, 6'b000000, 8'h00);
    chk("ab_count", instr_count, 32'd0);
    rst = 1'b0;
    expect_cyc("ab_fetch", 3'd0, 6'b111000, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the 31-instruction MIPS core.
- Consumes the 32-bit one-hot instruction code produced by the instruction decoder and sequences the shared PC, IR, register file, ALU and memory ports over FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memory.
- Traps on illegal codes and memory timeouts, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 255, max cycles a memory request may wait for ready before trap; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- code  in  32  one-hot instruction code. Bit map: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr, 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lui, 23 lw, 24 sw, 25 beq, 26 bne, 27 slti, 28 sltiu, 29 j, 30 jal.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction fetch complete.
- dmem_ready  in  1  data access complete.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load IR.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs.
- rf_we  out  1  register write enable.
- rf_wsel  out  2  0 rd, 1 rt, 2 $31.
- rf_dsel  out  2  0 ALU, 1 memory data, 2 PC (link).
- alu_bsrc  out  1  0 rt, 1 immediate.
- ext_sign  out  1  1 sign-extend imm, 0 zero-extend.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 store, 0 load; valid with dmem_req.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- trap  out  1  sticky fault flag.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset:
  - While rst=1 all strobes are 0: imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we.
  - pc_src, rf_wsel and rf_dsel are 0; alu_bsrc and ext_sign are 0.
  - trap=0, instr_count=0, internal wait counter=0.
  - state=FETCH on the first cycle after rst falls.
  - rst mid-instruction aborts it: no write occurs in the cycle rst is high.
- Outputs are combinational from state, code_q and the ready inputs. code_q is the registered copy of code captured on the DECODE cycle; in DECODE itself, outputs use code directly.
- FETCH:
  - imem_req=1 and held until imem_ready=1.
  - On the ready cycle: ir_we=1, pc_we=1 with pc_src=0; next state is DECODE.
- DECODE: capture code_q. Next state by class:
  - Bit count of code is not exactly 1 (covers 0, multiple bits, X/Z): TRAP.
  - j: pc_we=1, pc_src=2, go to FETCH; retire.
  - jr: pc_we=1, pc_src=3, go to FETCH; retire.
  - jal: pc_we=1, pc_src=2, go to WB.
  - All others: go to EXEC.
- EXEC:
  - alu_bsrc=1 for bits 17-28; ext_sign=1 for 17, 18, 23-28; ext_sign=0 for 19-22.
  - beq taken iff alu_zero=1; bne taken iff alu_zero=0. Taken: pc_we=1, pc_src=1. Then go to FETCH; retire.
  - lw/sw: go to MEM. ALU and lui ops: go to WB.
- MEM:
  - dmem_req=1, dmem_we=1 for sw, held until dmem_ready=1.
  - sw then goes to FETCH and retires; lw goes to WB.
- WB (exactly one cycle, rf_we=1):
  - R-type ALU ops: rf_wsel=0, rf_dsel=0.
  - I-type ALU ops and lui: rf_wsel=1, rf_dsel=0.
  - lw: rf_wsel=1, rf_dsel=1.
  - jal: rf_wsel=2, rf_dsel=2.
  - Next state FETCH; retire.
- Latency with immediate ready:
  - ALU ops: 4 cycles. lw: 5. sw: 4. Branches: 3. j/jr: 2. jal: 3.
- Memory timeout:
  - The wait counter counts cycles with req=1 and ready=0 in FETCH or MEM, and clears on ready or on state change.
  - If the counter reaches MEM_TIMEOUT (nonzero), next state is TRAP.
  - Ready arriving on the same cycle the limit is reached wins: the access completes and no trap is taken.
- TRAP: all strobes 0, trap=1, held until rst.
- instr_count increments by 1 on each retire cycle and saturates at all-ones.
- alu_zero is ignored outside EXEC; imem_ready and dmem_ready are ignored outside their request states.

Test Plan:
- Reset, then code=bit0 (add) with imem_ready tied 1 → states 0,1,2,4,0; rf_we=1 with rf_wsel=0 only in WB; instr_count=1 after 4 cycles.
- lw (bit23) with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then WB with rf_dsel=1 and rf_wsel=1; total 8 cycles.
- beq (bit25): alu_zero=1 gives pc_we=1, pc_src=1 in EXEC; repeat with alu_zero=0 gives pc_we=0. bne (bit26) gives the inverse; each retires in 3 cycles.
- jal (bit30) → DECODE pc_we=1, pc_src=2; WB rf_wsel=2, rf_dsel=2; 3 cycles. Also jr (bit16) gives pc_src=3 in 2 cycles.
- code=0 in DECODE, and separately code=bit0|bit1 → TRAP, trap=1, no strobes; stays in TRAP until rst=1 clears it to FETCH with instr_count=0.
- MEM_TIMEOUT=4, imem_ready held 0 → TRAP after 4 wait cycles. Then with ready asserted on the 4th wait cycle → no trap, DECODE next. Also assert rst during MEM of sw → dmem_we never seen high after rst.
